apb_conv_ctrl_q: RTL and testbench

//  APB-slave control block for the conv engine. Software programs a layer descriptor
//  (in_ch, out_ch, flen) and pushes it into a QDEPTH-entry descriptor queue. An internal

---
 rtl/conv_ctrl_pkg.sv | 51 +++++
 rtl/conv_desc_fifo.sv | 68 ++++++
 rtl/apb_conv_ctrl_q.sv | 250 +++++++++++++++++++++++++
 tb/tb_apb_conv_ctrl_q.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the conv engine APB control block.
//   - phase command encodings driven to the engine
//   - register byte offsets of the APB register map
//   - CTRL / DONE register bit positions
//   - sequencer FSM state type and its state-to-command mapping
package conv_ctrl_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_LD_IN = 3'd1;
  localparam logic [2:0] CMD_LD_B  = 3'd2;
  localparam logic [2:0] CMD_LD_W  = 3'd3;
  localparam logic [2:0] CMD_RUN   = 3'd4;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_IN_CH  = 8'h04;
  localparam logic [7:0] OFF_OUT_CH = 8'h08;
  localparam logic [7:0] OFF_FLEN   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_DONE   = 8'h20;
  localparam logic [7:0] OFF_LAT    = 8'h30;
  localparam logic [7:0] OFF_LAYERS = 8'h34;

  localparam int CTRL_PUSH   = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int DONE_LAYER = 0;
  localparam int DONE_OVF   = 1;
  localparam int DONE_ABORT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_IN,
    ST_LD_B,
    ST_LD_W,
    ST_RUN,
    ST_DONE
  } state_t;

  // Command presented to the engine while the sequencer sits in a state.
  function automatic logic [2:0] state_cmd(input state_t s);
    case (s)
      ST_LD_IN: return CMD_LD_IN;
      ST_LD_B:  return CMD_LD_B;
      ST_LD_W:  return CMD_LD_W;
      ST_RUN:   return CMD_RUN;
      default:  return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/conv_desc_fifo.sv
// Synchronous descriptor FIFO for the conv sequencer.
// Ports:
//   PCLK, PRESETB   clock, asynchronous active-low reset
//   push, wdata     enqueue request and entry; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop             dequeue the head (ignored when empty)
//   flush           empty the queue; wins over push and pop
//   rdata           current head entry (show-ahead)
//   full, empty     occupancy flags
//   count           number of valid entries
module conv_desc_fifo
  import conv_ctrl_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESETB,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  // A push into a full queue is still fine when the head leaves this cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge PCLK) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_conv_ctrl_q.sv
// APB slave control block for the conv engine.
// Software stages a layer descriptor (in_ch, out_ch, flen) and pushes it into a
// descriptor queue; the sequencer runs each queued layer through
// LD_IN -> LD_B -> LD_W -> RUN -> DONE, handshaking on the engine done pulses.
// Ports:
//   PCLK, PRESETB          APB clock, asynchronous active-low reset
//   PADDR..PWDATA          APB request (decode on PADDR[ADDR_W-1:2])
//   PRDATA, PREADY,        APB response; PRDATA valid in the access phase only,
//   PSLVERR                zero wait states, PSLVERR in the access phase only
//   clk_counter            free-running cycle count used for layer latency
//   input_done..conv_done  engine phase-complete levels (edge-detected here)
//   command                phase command to the engine
//   in_ch, out_ch, flen    descriptor of the active layer
//   irq                    level interrupt
module apb_conv_ctrl_q
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CH_W   = 9,
  parameter int FLEN_W = 6,
  parameter int QDEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETB,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [31:0]       clk_counter,
  input  logic              input_done,
  input  logic              bias_done,
  input  logic              weight_done,
  input  logic              conv_done,
  output logic [2:0]        command,
  output logic [CH_W-1:0]   in_ch,
  output logic [CH_W-1:0]   out_ch,
  output logic [FLEN_W-1:0] flen,
  output logic              irq
);

  localparam int DW = 2*CH_W + FLEN_W;
  localparam int CW = $clog2(QDEPTH) + 1;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [7:0] off);
    return a[ADDR_W-1:2] == (ADDR_W-2)'(off[7:2]);
  endfunction

  state_t            state;
  state_t            nxt;
  logic              irq_en;
  logic [CH_W-1:0]   stg_in_ch;
  logic [CH_W-1:0]   stg_out_ch;
  logic [FLEN_W-1:0] stg_flen;
  logic [2:0]        done_flags;
  logic [2:0]        set_flags;
  logic [2:0]        w1c;
  logic [31:0]       lat;
  logic [31:0]       layers;
  logic [31:0]       start_q;
  logic [31:0]       rdata;

  logic              in_q, bias_q, wgt_q, conv_q;
  logic              in_edge, bias_edge, wgt_edge, conv_edge;

  logic [DW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic hit_ctrl, hit_in_ch, hit_out_ch, hit_flen;
  logic hit_status, hit_done, hit_lat, hit_layers;
  logic mapped, read_only;
  logic access, setup_rd, wr;
  logic ctrl_push, push_rej, err;
  logic push, pop, flush, busy, commit;

  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:CH_W]};

  // APB decode
  assign access     = PSEL & PENABLE;
  assign setup_rd   = PSEL & ~PENABLE & ~PWRITE;

  assign hit_ctrl   = hit(PADDR, OFF_CTRL);
  assign hit_in_ch  = hit(PADDR, OFF_IN_CH);
  assign hit_out_ch = hit(PADDR, OFF_OUT_CH);
  assign hit_flen   = hit(PADDR, OFF_FLEN);
  assign hit_status = hit(PADDR, OFF_STATUS);
  assign hit_done   = hit(PADDR, OFF_DONE);
  assign hit_lat    = hit(PADDR, OFF_LAT);
  assign hit_layers = hit(PADDR, OFF_LAYERS);

  assign mapped    = hit_ctrl | hit_in_ch | hit_out_ch | hit_flen |
                     hit_status | hit_done | hit_lat | hit_layers;
  assign read_only = hit_status | hit_lat | hit_layers;

  // FLUSH in the same write cancels the PUSH, so it can never overflow.
  assign ctrl_push = PWDATA[CTRL_PUSH] & ~PWDATA[CTRL_FLUSH];
  assign pop       = (state == ST_DONE);
  assign push_rej  = hit_ctrl & PWRITE & ctrl_push & fifo_full & ~pop;
  assign err       = access & (~mapped | (PWRITE & read_only) | push_rej);
  assign wr        = access & PWRITE & ~err;

  assign push   = wr & hit_ctrl & ctrl_push;
  assign flush  = wr & hit_ctrl & PWDATA[CTRL_FLUSH];
  assign busy   = (state != ST_IDLE);
  // A flush landing on the DONE cycle discards the layer rather than counting it.
  assign commit = (state == ST_DONE) & ~flush;

  assign PREADY  = 1'b1;
  assign PSLVERR = err;
  assign irq     = irq_en & (|done_flags);

  conv_desc_fifo #(
    .W     (DW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESETB (PRESETB),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({stg_in_ch, stg_out_ch, stg_flen}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Engine done edge detection
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      in_q   <= 1'b0;
      bias_q <= 1'b0;
      wgt_q  <= 1'b0;
      conv_q <= 1'b0;
    end else begin
      in_q   <= input_done;
      bias_q <= bias_done;
      wgt_q  <= weight_done;
      conv_q <= conv_done;
    end
  end

  assign in_edge   = input_done  & ~in_q;
  assign bias_edge = bias_done   & ~bias_q;
  assign wgt_edge  = weight_done & ~wgt_q;
  assign conv_edge = conv_done   & ~conv_q;

  // Sequencer FSM
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) nxt = ST_LD_IN;
      ST_LD_IN: if (in_edge)     nxt = ST_LD_B;
      ST_LD_B:  if (bias_edge)   nxt = ST_LD_W;
      ST_LD_W:  if (wgt_edge)    nxt = ST_RUN;
      ST_RUN:   if (conv_edge)   nxt = ST_DONE;
      ST_DONE:                   nxt = ST_IDLE;
      default:                   nxt = ST_IDLE;
    endcase
    if (flush) nxt = ST_IDLE;
  end

  // Registered engine outputs; the descriptor latches the head on layer start
  // so it stays stable even if software pushes or the head pops later.
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      command <= CMD_IDLE;
      in_ch   <= '0;
      out_ch  <= '0;
      flen    <= '0;
    end else begin
      command <= state_cmd(nxt);
      if (state == ST_IDLE && nxt == ST_LD_IN) {in_ch, out_ch, flen} <= fifo_rdata;
    end
  end

  always_ff @(posedge PCLK) begin
    if (state == ST_LD_W && nxt == ST_RUN) start_q <= clk_counter;
  end

  // Latency (modular subtraction handles counter wrap) and layer count
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      lat    <= '0;
      layers <= '0;
    end else if (commit) begin
      lat    <= clk_counter - start_q;
      layers <= layers + 32'd1;
    end
  end

  // Software-visible registers
  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      irq_en     <= 1'b0;
      stg_in_ch  <= '0;
      stg_out_ch <= '0;
      stg_flen   <= '0;
    end else if (wr) begin
      if (hit_ctrl)   irq_en     <= PWDATA[CTRL_IRQ_EN];
      if (hit_in_ch)  stg_in_ch  <= PWDATA[CH_W-1:0];
      if (hit_out_ch) stg_out_ch <= PWDATA[CH_W-1:0];
      if (hit_flen)   stg_flen   <= PWDATA[FLEN_W-1:0];
    end
  end

  // Sticky status: a set in the same cycle as a W1C wins.
  always_comb begin
    set_flags             = '0;
    set_flags[DONE_LAYER] = commit;
    set_flags[DONE_OVF]   = access & push_rej;
    set_flags[DONE_ABORT] = flush & busy;
    w1c                   = (wr & hit_done) ? PWDATA[2:0] : 3'b000;
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) done_flags <= '0;
    else          done_flags <= (done_flags & ~w1c) | set_flags;
  end

  // Read path: sampled in the setup phase, zero outside the access phase
  always_comb begin
    rdata = '0;
    if (hit_ctrl)   rdata[CTRL_IRQ_EN] = irq_en;
    if (hit_in_ch)  rdata = 32'(stg_in_ch);
    if (hit_out_ch) rdata = 32'(stg_out_ch);
    if (hit_flen)   rdata = 32'(stg_flen);
    if (hit_status) rdata = {16'b0, 8'(fifo_count), 4'b0, fifo_full, fifo_empty, busy, 1'b0};
    if (hit_done)   rdata = {29'b0, done_flags};
    if (hit_lat)    rdata = lat;
    if (hit_layers) rdata = layers;
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB)      PRDATA <= '0;
    else if (setup_rd) PRDATA <= rdata;
    else               PRDATA <= '0;
  end

endmodule

// File: tb/tb_apb_conv_ctrl_q.sv
// Directed bench for apb_conv_ctrl_q: APB register access, descriptor queue,
// sequencer phases, latency/wrap, flush/abort, overflow and interrupt.
module tb_apb_conv_ctrl_q;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_IN_CH  = 12'h004;
  localparam logic [11:0] A_OUT_CH = 12'h008;
  localparam logic [11:0] A_FLEN   = 12'h00C;
  localparam logic [11:0] A_STATUS = 12'h010;
  localparam logic [11:0] A_DONE   = 12'h020;
  localparam logic [11:0] A_LAT    = 12'h030;
  localparam logic [11:0] A_LAYERS = 12'h034;

  logic        PCLK = 1'b0;
  logic        PRESETB;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] clk_counter;
  logic        input_done, bias_done, weight_done, conv_done;
  logic [2:0]  command;
  logic [8:0]  in_ch, out_ch;
  logic [5:0]  flen;
  logic        irq;

  logic [31:0] cyc = 32'd0;
  logic [31:0] cnt_off = 32'd0;

  int n_assert = 0;
  int n_fail   = 0;

  logic        e;
  logic [31:0] d, pre, post;

  apb_conv_ctrl_q #(.ADDR_W(12), .CH_W(9), .FLEN_W(6), .QDEPTH(4)) dut (
    .PCLK        (PCLK),
    .PRESETB     (PRESETB),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .clk_counter (clk_counter),
    .input_done  (input_done),
    .bias_done   (bias_done),
    .weight_done (weight_done),
    .conv_done   (conv_done),
    .command     (command),
    .in_ch       (in_ch),
    .out_ch      (out_ch),
    .flen        (flen),
    .irq         (irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 32'd1;
  assign clk_counter = cyc + cnt_off;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] wd, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = wd;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] rd, output logic err,
                          output logic [31:0] pre_v, output logic [31:0] post_v);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 pre_v = PRDATA;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 rd = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1 post_v = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd, p0, p1;
    logic        er;
    apb_read(a, rd, er, p0, p1);
    chk(tag, rd, exp);
  endtask

  task automatic wait_cmd(input logic [2:0] exp, input string tag);
    int n = 0;
    while (command !== exp && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk(tag, 32'(command), 32'(exp));
  endtask

  // Raise one done line dly negedges from now, drop it one cycle later.
  task automatic pulse(input int which, input int dly);
    repeat (dly) @(negedge PCLK);
    case (which)
      0: input_done  = 1'b1;
      1: bias_done   = 1'b1;
      2: weight_done = 1'b1;
      default: conv_done = 1'b1;
    endcase
    @(negedge PCLK);
    case (which)
      0: input_done  = 1'b0;
      1: bias_done   = 1'b0;
      2: weight_done = 1'b0;
      default: conv_done = 1'b0;
    endcase
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETB = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    input_done = 1'b0; bias_done = 1'b0; weight_done = 1'b0; conv_done = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    chk("rst_command", 32'(command), 32'd0);
    chk("rst_in_ch", 32'(in_ch), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd1);
    PRESETB = 1'b1;
    rd_chk(A_STATUS, 32'h0000_0004, "rst_status");
    rd_chk(A_LAYERS, 32'd0, "rst_layers");
    rd_chk(A_LAT, 32'd0, "rst_lat");

    // Test 1: single layer 3/16/32
    apb_write(A_IN_CH, 32'd3, e);
    apb_write(A_OUT_CH, 32'd16, e);
    apb_write(A_FLEN, 32'd32, e);
    apb_write(A_CTRL, 32'h1, e);
    chk("t1_push_err", 32'(e), 32'd0);
    wait_cmd(3'd1, "t1_cmd_ld_in");
    chk("t1_in_ch", 32'(in_ch), 32'd3);
    chk("t1_out_ch", 32'(out_ch), 32'd16);
    chk("t1_flen", 32'(flen), 32'd32);
    pulse(0, 5);
    wait_cmd(3'd2, "t1_cmd_ld_b");
    pulse(1, 5);
    wait_cmd(3'd3, "t1_cmd_ld_w");
    pulse(2, 5);
    wait_cmd(3'd4, "t1_cmd_run");
    // conv_done rises 5 negedges after RUN entry: edge seen at RUN+6,
    // DONE commits at RUN+7 -> LAT = 7.
    pulse(3, 5);
    wait_cmd(3'd0, "t1_cmd_done");
    chk("t1_flen_stable", 32'(flen), 32'd32);
    repeat (2) @(negedge PCLK);
    rd_chk(A_LAT, 32'd7, "t1_lat");
    rd_chk(A_LAYERS, 32'd1, "t1_layers");
    rd_chk(A_DONE, 32'h1, "t1_done");
    rd_chk(A_STATUS, 32'h0000_0004, "t1_status_idle");
    apb_write(A_DONE, 32'h1, e);
    rd_chk(A_DONE, 32'h0, "t1_done_clr");

    // Test 2: overflow with the engine stalled in LD_IN
    for (int i = 0; i < 4; i++) apb_write(A_CTRL, 32'h1, e);
    chk("t2_push4_err", 32'(e), 32'd0);
    apb_write(A_CTRL, 32'h1, e);
    chk("t2_push5_err", 32'(e), 32'd1);
    rd_chk(A_STATUS, 32'h0000_040A, "t2_status_full");
    rd_chk(A_DONE, 32'h2, "t2_overflow");
    chk("t2_irq_off", 32'(irq), 32'd0);
    apb_write(A_CTRL, 32'h4, e);
    chk("t2_irq_on", 32'(irq), 32'd1);
    apb_write(A_CTRL, 32'h2, e);
    rd_chk(A_STATUS, 32'h0000_0004, "t2_status_flushed");
    rd_chk(A_DONE, 32'h6, "t2_done_abort");
    apb_write(A_DONE, 32'h7, e);

    // Test 3: FLUSH during LD_W
    apb_write(A_CTRL, 32'h1, e);
    apb_write(A_CTRL, 32'h1, e);
    wait_cmd(3'd1, "t3_cmd_ld_in");
    pulse(0, 2);
    wait_cmd(3'd2, "t3_cmd_ld_b");
    pulse(1, 2);
    wait_cmd(3'd3, "t3_cmd_ld_w");
    apb_write(A_CTRL, 32'h2, e);
    chk("t3_cmd_after_flush", 32'(command), 32'd0);
    rd_chk(A_STATUS, 32'h0000_0004, "t3_status_empty");
    rd_chk(A_DONE, 32'h4, "t3_abort");
    pulse(2, 2);
    repeat (3) @(negedge PCLK);
    chk("t3_wdone_ignored", 32'(command), 32'd0);
    rd_chk(A_LAYERS, 32'd1, "t3_layers");
    apb_write(A_DONE, 32'h7, e);

    // Test 4: error responses and read-data timing
    apb_read(12'h03C, d, e, pre, post);
    chk("t4_unmapped_err", 32'(e), 32'd1);
    chk("t4_unmapped_data", d, 32'd0);
    apb_write(A_STATUS, 32'h3, e);
    chk("t4_ro_write_err", 32'(e), 32'd1);
    rd_chk(A_STATUS, 32'h0000_0004, "t4_status_unchanged");
    apb_write(A_IN_CH, 32'h55, e);
    chk("t4_in_ch_write_err", 32'(e), 32'd0);
    apb_read(A_IN_CH, d, e, pre, post);
    chk("t4_prdata_setup", pre, 32'd0);
    chk("t4_prdata_access", d, 32'h55);
    chk("t4_prdata_after", post, 32'd0);
    chk("t4_read_err", 32'(e), 32'd0);

    // Test 5: input_done held high across two layers
    apb_write(A_IN_CH, 32'd5, e);
    apb_write(A_OUT_CH, 32'd6, e);
    apb_write(A_FLEN, 32'd7, e);
    apb_write(A_CTRL, 32'h1, e);
    apb_write(A_IN_CH, 32'd9, e);
    apb_write(A_CTRL, 32'h1, e);
    wait_cmd(3'd1, "t5_l1_ld_in");
    chk("t5_l1_in_ch", 32'(in_ch), 32'd5);
    @(negedge PCLK);
    input_done = 1'b1;
    wait_cmd(3'd2, "t5_l1_ld_b");
    pulse(1, 1);
    wait_cmd(3'd3, "t5_l1_ld_w");
    pulse(2, 1);
    wait_cmd(3'd4, "t5_l1_run");
    pulse(3, 1);
    wait_cmd(3'd0, "t5_l1_done");
    wait_cmd(3'd1, "t5_l2_ld_in");
    chk("t5_l2_in_ch", 32'(in_ch), 32'd9);
    chk("t5_l2_out_ch", 32'(out_ch), 32'd6);
    repeat (10) @(negedge PCLK);
    chk("t5_l2_still_ld_in", 32'(command), 32'd1);
    input_done = 1'b0;
    @(negedge PCLK);
    input_done = 1'b1;
    wait_cmd(3'd2, "t5_l2_ld_b");
    input_done = 1'b0;
    pulse(1, 1);
    wait_cmd(3'd3, "t5_l2_ld_w");
    pulse(2, 1);
    wait_cmd(3'd4, "t5_l2_run");
    pulse(3, 1);
    wait_cmd(3'd0, "t5_l2_done");
    repeat (3) @(negedge PCLK);
    rd_chk(A_LAYERS, 32'd3, "t5_layers");
    rd_chk(A_DONE, 32'h1, "t5_done");
    apb_write(A_DONE, 32'h7, e);

    // Test 6: latency across clk_counter wrap
    @(negedge PCLK);
    cnt_off = 32'hFFFF_FFF0 - cyc;
    apb_write(A_CTRL, 32'h1, e);
    wait_cmd(3'd1, "t6_ld_in");
    pulse(0, 1);
    wait_cmd(3'd2, "t6_ld_b");
    pulse(1, 1);
    wait_cmd(3'd3, "t6_ld_w");
    pulse(2, 1);
    wait_cmd(3'd4, "t6_run");
    // conv_done rises 30 negedges after RUN entry: edge seen at RUN+31,
    // DONE commits at RUN+32 -> LAT = 32 although the counter wrapped.
    pulse(3, 30);
    wait_cmd(3'd0, "t6_done");
    repeat (2) @(negedge PCLK);
    rd_chk(A_LAT, 32'd32, "t6_lat_wrap");
    rd_chk(A_LAYERS, 32'd4, "t6_layers");
    apb_write(A_CTRL, 32'h4, e);
    chk("t6_irq_on", 32'(irq), 32'd1);
    apb_write(A_DONE, 32'h1, e);
    rd_chk(A_DONE, 32'h0, "t6_done_clr");
    chk("t6_irq_off", 32'(irq), 32'd0);

    // Reset asserted mid-layer
    apb_write(A_CTRL, 32'h1, e);
    wait_cmd(3'd1, "rst2_ld_in");
    pulse(0, 1);
    wait_cmd(3'd2, "rst2_ld_b");
    #2 PRESETB = 1'b0;
    #1;
    chk("rst2_command", 32'(command), 32'd0);
    chk("rst2_in_ch", 32'(in_ch), 32'd0);
    @(negedge PCLK);
    PRESETB = 1'b1;
    rd_chk(A_STATUS, 32'h0000_0004, "rst2_status");
    rd_chk(A_CTRL, 32'h0, "rst2_ctrl");
    rd_chk(A_LAYERS, 32'd0, "rst2_layers");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
